// File: rtl/pc_unit.sv
// pc_unit: program-counter generator feeding the fetch stage's pc_in.
// Sequences BOOT -> RUN -> HALT and applies stall, branch, jump and return
// redirects with the priority ret > jump > branch_taken > stall > increment.
// Optional feature macro: PC_UNIT_RAS_EN builds the return-address stack
// used by call/ret. Without it, call is ignored, ret redirects to
// jump_target, and both stack flags read as 0.
module pc_unit #(
   parameter int                  PC_WIDTH     = 16,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                  RAS_DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                call,
   input  logic                ret,
   input  logic                halt,
   input  logic                resume,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                pc_valid,
   output logic                halted,
   output logic                ras_underflow,
   output logic                ras_overflow
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   logic [1:0]          state;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] pc_next;
   logic                running;

   // Sequential successor; wraps modulo 2^PC_WIDTH with no flag.
   assign pc_inc  = pc_out + PC_WIDTH'(1);
   assign running = (state == ST_RUN);

`ifdef PC_UNIT_RAS_EN
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]    ras_ptr;    // next slot to write; top of stack is ras_ptr-1
   logic [PTR_W:0]      ras_count;  // live entries, saturates at RAS_DEPTH
   logic [PTR_W-1:0]    ras_top_idx;
   logic                ras_empty;
   logic                ras_full;
   logic                do_push;
   logic                do_pop;
   logic                ret_empty;

   assign ras_top_idx = ras_ptr - PTR_W'(1);
   assign ras_empty   = (ras_count == '0);
   assign ras_full    = (ras_count == (PTR_W+1)'(RAS_DEPTH));
`else
   // Stack depth and call have no function without the return-address stack.
   localparam int unused_ras_depth = RAS_DEPTH;
   logic          unused_call;
   assign unused_call = call;
`endif

   // Next-PC selection in RUN, highest-priority redirect first.
   always_comb begin
      // NOTE: every output of this block gets a default before the priority
      // chain so that no path leaves a value unassigned and infers a latch.
      pc_next = pc_out;
`ifdef PC_UNIT_RAS_EN
      do_push   = 1'b0;
      do_pop    = 1'b0;
      ret_empty = 1'b0;
`endif
      if (ret) begin
`ifdef PC_UNIT_RAS_EN
         if (ras_empty) begin
            pc_next   = pc_inc;
            ret_empty = 1'b1;
         end else begin
            pc_next = ras_mem[ras_top_idx];
            do_pop  = 1'b1;
         end
`else
         pc_next = jump_target;
`endif
      end else if (jump) begin
         pc_next = jump_target;
`ifdef PC_UNIT_RAS_EN
         do_push = call;
`endif
      end else if (branch_taken) begin
         pc_next = branch_target;
      end else if (!stall) begin
         pc_next = pc_inc;
      end
   end

   // Control FSM and registered PC / status outputs.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state    <= ST_BOOT;
         pc_out   <= RESET_VECTOR;
         pc_valid <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state    <= ST_RUN;
               pc_valid <= 1'b1;
            end
            ST_RUN: begin
               pc_out <= pc_next;
               if (halt) begin
                  state    <= ST_HALT;
                  pc_valid <= 1'b0;
                  halted   <= 1'b1;
               end
            end
            ST_HALT: begin
               if (resume && !halt) begin
                  state    <= ST_RUN;
                  pc_valid <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            default: begin
               state    <= ST_BOOT;
               pc_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_UNIT_RAS_EN
   // Stack pointer, occupancy and the two stack status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ras_ptr       <= '0;
         ras_count     <= '0;
         ras_underflow <= 1'b0;
         ras_overflow  <= 1'b0;
      end else begin
         ras_underflow <= running && ret_empty;
         if (running && do_push) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_full) begin
               ras_overflow <= 1'b1;
            end else begin
               ras_count <= ras_count + (PTR_W+1)'(1);
            end
         end else if (running && do_pop) begin
            ras_ptr   <= ras_top_idx;
            ras_count <= ras_count - (PTR_W+1)'(1);
         end
      end
   end

   // Stack storage; a push into a full stack lands on the oldest entry.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; clearing ras_count on rst makes
      // every stale entry unreachable, so resetting the array buys nothing.
      if (running && do_push) begin
         ras_mem[ras_ptr] <= pc_inc;
      end
   end
`else
   assign ras_underflow = 1'b0;
   assign ras_overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit. A behavioural model (flags
// plus a queue for the return stack) is compared against the DUT on every
// falling edge, with directed literal checks that pin the model, followed by
// a randomized run including asynchronous resets.
// Honours PC_UNIT_RAS_EN the same way the design does.
module tb_pc_unit;

   localparam int          PC_WIDTH     = 16;
   localparam logic [15:0] RESET_VECTOR = 16'h0000;
   localparam int          RAS_DEPTH    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall, branch_taken, jump, call, ret, halt, resume;
   logic [15:0] branch_target, jump_target;
   logic [15:0] pc_out;
   logic        pc_valid, halted, ras_underflow, ras_overflow;

   int n_checks = 0;
   int n_errors = 0;

   pc_unit #(
      .PC_WIDTH     (PC_WIDTH),
      .RESET_VECTOR (RESET_VECTOR),
      .RAS_DEPTH    (RAS_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .call          (call),
      .ret           (ret),
      .halt          (halt),
      .resume        (resume),
      .pc_out        (pc_out),
      .pc_valid      (pc_valid),
      .halted        (halted),
      .ras_underflow (ras_underflow),
      .ras_overflow  (ras_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_pc;
   logic        m_booted, m_valid, m_halted, m_unf, m_ovf;
   logic [15:0] m_stack[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc     = RESET_VECTOR;
         m_booted = 1'b0;
         m_valid  = 1'b0;
         m_halted = 1'b0;
         m_unf    = 1'b0;
         m_ovf    = 1'b0;
         m_stack.delete();
      end else begin
         m_unf = 1'b0;
         if (!m_booted) begin
            m_booted = 1'b1;
            m_valid  = 1'b1;
         end else if (m_halted) begin
            if (resume && !halt) begin
               m_halted = 1'b0;
               m_valid  = 1'b1;
            end
         end else begin
            logic [15:0] nxt;
            nxt = m_pc + 16'd1;
            if (ret) begin
`ifdef PC_UNIT_RAS_EN
               if (m_stack.size() == 0) m_unf = 1'b1;
               else                     nxt = m_stack.pop_back();
`else
               nxt = jump_target;
`endif
            end else if (jump) begin
`ifdef PC_UNIT_RAS_EN
               if (call) begin
                  m_stack.push_back(m_pc + 16'd1);
                  if (m_stack.size() > RAS_DEPTH) begin
                     void'(m_stack.pop_front());
                     m_ovf = 1'b1;
                  end
               end
`endif
               nxt = jump_target;
            end else if (branch_taken) begin
               nxt = branch_target;
            end else if (stall) begin
               nxt = m_pc;
            end
            m_pc = nxt;
            if (halt) begin
               m_halted = 1'b1;
               m_valid  = 1'b0;
            end
         end
      end
   end

   // Compare the DUT with the model on every falling edge.
   always @(negedge clk) begin
      check("model_pc_out",   {16'd0, pc_out}, {16'd0, m_pc});
      check("model_pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
      check("model_halted",   {31'd0, halted}, {31'd0, m_halted});
      check("model_underflow",{31'd0, ras_underflow}, {31'd0, m_unf});
      check("model_overflow", {31'd0, ras_overflow}, {31'd0, m_ovf});
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
      halt = 0; resume = 0; branch_target = 16'h0; jump_target = 16'h0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      rst = 1'b1;
      repeat (3) tick();
      check("reset_pc",    {16'd0, pc_out}, 32'h0);
      check("reset_valid", {31'd0, pc_valid}, 32'h0);
      check("reset_halted",{31'd0, halted}, 32'h0);
      check("reset_unf",   {31'd0, ras_underflow}, 32'h0);
      check("reset_ovf",   {31'd0, ras_overflow}, 32'h0);
      rst = 1'b0;

      // Sequential issue after reset.
      tick();
      check("boot_pc", {16'd0, pc_out}, 32'h0);
      check("boot_valid", {31'd0, pc_valid}, 32'h1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("seq_pc", {16'd0, pc_out}, i);
      end

      // Stall holds, redirect overrides stall.
      stall = 1;
      tick(); check("stall_pc1", {16'd0, pc_out}, 32'h5);
      tick(); check("stall_pc2", {16'd0, pc_out}, 32'h5);
      branch_taken = 1; branch_target = 16'h0040;
      tick(); check("branch_over_stall", {16'd0, pc_out}, 32'h40);
      idle();

      // Wrap-around.
      jump = 1; jump_target = 16'hFFFE;
      tick(); check("jump_fffe", {16'd0, pc_out}, 32'hFFFE);
      idle();
      tick(); check("wrap_ffff", {16'd0, pc_out}, 32'hFFFF);
      tick(); check("wrap_0000", {16'd0, pc_out}, 32'h0000);
      tick(); check("wrap_0001", {16'd0, pc_out}, 32'h0001);

      // Call / return.
      jump = 1; jump_target = 16'h0010;
      tick(); check("jump_0010", {16'd0, pc_out}, 32'h10);
      jump = 1; call = 1; jump_target = 16'h0100;
      tick(); check("call_0100", {16'd0, pc_out}, 32'h100);
      idle();
      tick(); check("call_adv1", {16'd0, pc_out}, 32'h101);
      tick(); check("call_adv2", {16'd0, pc_out}, 32'h102);
`ifdef PC_UNIT_RAS_EN
      ret = 1;
      tick(); check("ret_pc", {16'd0, pc_out}, 32'h11);
      check("ret_no_unf", {31'd0, ras_underflow}, 32'h0);
      tick(); check("ret_empty_pc", {16'd0, pc_out}, 32'h12);
      check("ret_empty_unf", {31'd0, ras_underflow}, 32'h1);
      idle();
      tick(); check("unf_pulse_end", {31'd0, ras_underflow}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         jump = 1; call = 1; jump_target = 16'h0200 + 16'(i);
         tick();
         if (i == 3) check("ovf_not_yet", {31'd0, ras_overflow}, 32'h0);
      end
      check("ovf_set", {31'd0, ras_overflow}, 32'h1);
      idle(); ret = 1;
      tick(); check("ret_after_ovf", {16'd0, pc_out}, 32'h204);
      idle();
      tick(); check("ovf_sticky", {31'd0, ras_overflow}, 32'h1);
`else
      ret = 1; jump_target = 16'h0077;
      tick(); check("ret_as_jump", {16'd0, pc_out}, 32'h77);
      check("ret_no_unf", {31'd0, ras_underflow}, 32'h0);
      idle();
      for (int i = 0; i < 5; i++) begin
         jump = 1; call = 1; jump_target = 16'h0200 + 16'(i);
         tick();
      end
      check("call_plain_jump", {16'd0, pc_out}, 32'h204);
      check("ovf_tied", {31'd0, ras_overflow}, 32'h0);
      idle();
`endif

      // Halt / resume.
      jump = 1; jump_target = 16'h0008;
      tick(); check("jump_8", {16'd0, pc_out}, 32'h8);
      idle(); halt = 1;
      tick(); check("halt_pc", {16'd0, pc_out}, 32'h9);
      check("halt_valid", {31'd0, pc_valid}, 32'h0);
      check("halt_halted", {31'd0, halted}, 32'h1);
      idle(); jump = 1; jump_target = 16'h0300;
      tick(); check("halt_ignores_jump", {16'd0, pc_out}, 32'h9);
      idle(); halt = 1; resume = 1;
      tick(); check("halt_and_resume", {31'd0, halted}, 32'h1);
      idle(); resume = 1;
      tick(); check("resume_pc", {16'd0, pc_out}, 32'h9);
      check("resume_valid", {31'd0, pc_valid}, 32'h1);
      check("resume_halted", {31'd0, halted}, 32'h0);
      idle();
      tick(); check("resume_next", {16'd0, pc_out}, 32'hA);

      // Asynchronous reset mid-run with a non-empty stack.
      jump = 1; call = 1; jump_target = 16'h0022;
      tick(); check("jump_22", {16'd0, pc_out}, 32'h22);
      idle();
      tick(); check("pc_23", {16'd0, pc_out}, 32'h23);
      #2 rst = 1'b1;
      #1 check("async_rst_pc", {16'd0, pc_out}, 32'h0);
      check("async_rst_valid", {31'd0, pc_valid}, 32'h0);
      tick(); rst = 1'b0;
      tick(); check("reboot_valid", {31'd0, pc_valid}, 32'h1);
      ret = 1; jump_target = 16'h0055;
      tick();
`ifdef PC_UNIT_RAS_EN
      check("post_rst_ret_pc", {16'd0, pc_out}, 32'h1);
      check("post_rst_unf", {31'd0, ras_underflow}, 32'h1);
`else
      check("post_rst_ret_pc", {16'd0, pc_out}, 32'h55);
`endif
      idle();

      // Randomized run against the model.
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst           = 1'b0;
         stall         = ($urandom_range(0, 3) == 0);
         branch_taken  = ($urandom_range(0, 9) == 0);
         jump          = ($urandom_range(0, 9) == 0);
         call          = ($urandom_range(0, 1) == 0);
         ret           = ($urandom_range(0, 11) == 0);
         halt          = ($urandom_range(0, 29) == 0);
         resume        = ($urandom_range(0, 3) == 0);
         branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                     : 16'($urandom);
         jump_target   = 16'($urandom);
         if ($urandom_range(0, 299) == 0) #2 rst = 1'b1;
      end
      tick();
      idle();
      rst = 1'b0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter generator sitting directly upstream of `InstructionFetch`. It drives the word address presented on the fetch stage's `pc_in` every cycle, advancing sequentially and applying stall, branch/jump redirect and halt/resume control from later pipeline stages. An optional return-address stack services call/return redirects without a target from the decoder.

## Interface
Parameters:
- `PC_WIDTH`, 16, width of the word address; matches fetch `pc_in`.
- `RESET_VECTOR`, 16'h0000, first PC issued after reset.
- `RAS_DEPTH`, 4, return-address stack entries. Power of two, ≥2. Used only with `PC_UNIT_RAS_EN`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hold `pc_out` this cycle.
- `branch_taken` in 1: redirect to `branch_target`.
- `branch_target` in PC_WIDTH: branch destination.
- `jump` in 1: redirect to `jump_target`.
- `jump_target` in PC_WIDTH: jump/call destination.
- `call` in 1: qualifies `jump`; push return address.
- `ret` in 1: return redirect.
- `halt` in 1: stop issuing.
- `resume` in 1: leave HALT.
- `pc_out` out PC_WIDTH: address to fetch `pc_in`.
- `pc_valid` out 1: `pc_out` is a live fetch request.
- `halted` out 1: state is HALT.
- `ras_underflow` out 1: one-cycle pulse, `ret` with empty stack.
- `ras_overflow` out 1: sticky, push onto full stack.

## Operation
- States: BOOT, RUN, HALT. All outputs registered.
- Reset values: `pc_out`=RESET_VECTOR, `pc_valid`=0, `halted`=0, `ras_underflow`=0, `ras_overflow`=0, stack count 0, state BOOT.
- BOOT: unconditionally → RUN on first edge after `rst` falls. `pc_valid`←1, `pc_out` stays RESET_VECTOR. All control inputs ignored in BOOT.
- RUN next-PC priority, highest first:
  1. `ret`: pop top of stack into `pc_out`. If stack is empty: `pc_out`←`pc_out`+1, pulse `ras_underflow`.
  2. `jump`: `pc_out`←`jump_target`. If `call`=1, also push `pc_out`+1.
  3. `branch_taken`: `pc_out`←`branch_target`.
  4. `stall`: hold.
  5. Otherwise: `pc_out`←`pc_out`+1.
- `call` without `jump`: ignored.
- `call`, `jump` and `ret` together: treated as `ret` only; no push.
- Redirects override `stall` (flush semantics).
- Increment is modulo 2^PC_WIDTH: 16'hFFFF → 16'h0000, with no flag.
- `halt` in RUN: this cycle's next-PC update is still applied. Next state is HALT, with `pc_valid`←0 and `halted`←1.
- HALT: `pc_out` frozen. `stall`, redirect, `call` and `ret` ignored; stack unchanged.
- `resume` in HALT: → RUN, `pc_valid`←1, `halted`←0, `pc_out` unchanged.
- `halt` and `resume` together in HALT: stay in HALT.
- Stack push when count=RAS_DEPTH: overwrite the oldest entry (circular), count saturates, set `ras_overflow`. `ras_overflow` clears only on `rst`.
- `rst` asserted mid-operation: immediately returns all state to reset values, including clearing the stack.

## Timing
- Single cycle from control to effect: a control input sampled at edge N determines `pc_out` after edge N.
- The fetch stage consumes `pc_out` combinationally as `pc_in`, so the instruction for `pc_out` appears one fetch latency later.
- First valid fetch: `pc_valid`=1 one edge after `rst` deasserts.
- `ras_underflow` is high for exactly the cycle following the offending `ret`.
- No handshake with fetch: `pc_valid`=0 means fetch output is don't-care.

## Configuration
- `PC_UNIT_RAS_EN` defined:
  - Return-address stack of RAS_DEPTH × PC_WIDTH is built.
  - `call` and `ret` behave as described above.
- `PC_UNIT_RAS_EN` undefined:
  - No stack storage.
  - `call` is ignored, so `jump`+`call` acts as a plain jump.
  - `ret` acts as a jump to `jump_target` at the same priority as `ret`.
  - `ras_underflow` and `ras_overflow` are tied to 0.

## Test plan
- Reset and sequential issue: hold `rst` 3 cycles, then release with all controls 0 → `pc_valid`=1 with `pc_out`=0 on the first edge, then 1, 2, 3, 4 on consecutive edges.
- Stall vs redirect: `stall`=1 for 2 cycles at `pc_out`=5 → stays 5. Then `stall`=1 with `branch_taken`=1 and `branch_target`=16'h0040 → 16'h0040.
- Wrap-around: `jump` to 16'hFFFE, then no control → 16'hFFFF, 16'h0000, 16'h0001.
- Call/return (RAS on):
  - `jump`+`call` to 16'h0100 at `pc_out`=16'h0010, advance 2 cycles, then `ret` → `pc_out`=16'h0011.
  - Issue a second `ret` → `pc_out` increments and `ras_underflow` pulses for 1 cycle.
  - Issue 5 nested calls with RAS_DEPTH=4 → `ras_overflow`=1.
- Halt/resume: `halt` at `pc_out`=8 → `pc_out`=9, `pc_valid`=0, `halted`=1. A `jump` while halted is ignored. `resume` → `pc_valid`=1 at 9, then 10.
- Async reset mid-run: assert `rst` between edges at `pc_out`=16'h0023 with a non-empty stack → `pc_out`=0 and `pc_valid`=0 immediately. After release, a `ret` pulses `ras_underflow` (stack empty).
